// File: rtl/router_port_drain_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// Package : router_pkg
// Shared types for the router port drain arbiter.
// Revision: 1.0
// =============================================================================
package router_pkg;

    localparam int c_DATA_W = 8;

    typedef logic [1:0] port_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/router_port_drain_arbiter_if.sv
`default_nettype none
// =============================================================================
// Interface : router_port_drain_arbiter_if
// Router-port side and downstream byte-stream side of the drain arbiter.
// Packet counters exist only when ARB_PKT_CNT_EN is defined.
// Revision: 1.0
// =============================================================================
interface router_port_drain_arbiter_if
    import router_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
`ifdef ARB_PKT_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) ();

    logic              ready_0, ready_1, ready_2, ready_3;
    logic [DATA_W-1:0] data_0, data_1, data_2, data_3;
    logic              read_0, read_1, read_2, read_3;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    port_idx_t         out_port;
    logic              out_sop;
    logic              out_eop;
    logic              busy;
`ifdef ARB_PKT_CNT_EN
    logic [CNT_W-1:0]  pkt_cnt_0, pkt_cnt_1, pkt_cnt_2, pkt_cnt_3;
`endif

    modport master (
        input  ready_0, ready_1, ready_2, ready_3,
        input  data_0, data_1, data_2, data_3,
        input  out_ready,
        output read_0, read_1, read_2, read_3,
        output out_valid, out_data, out_port, out_sop, out_eop, busy
`ifdef ARB_PKT_CNT_EN
        ,
        output pkt_cnt_0, pkt_cnt_1, pkt_cnt_2, pkt_cnt_3
`endif
    );

    modport slave (
        output ready_0, ready_1, ready_2, ready_3,
        output data_0, data_1, data_2, data_3,
        output out_ready,
        input  read_0, read_1, read_2, read_3,
        input  out_valid, out_data, out_port, out_sop, out_eop, busy
`ifdef ARB_PKT_CNT_EN
        ,
        input  pkt_cnt_0, pkt_cnt_1, pkt_cnt_2, pkt_cnt_3
`endif
    );

endinterface
`default_nettype wire

// File: rtl/router_port_drain_arbiter_rr.sv
`default_nettype none
// =============================================================================
// Module  : rr_arbiter_4
// Combinational 4-way round-robin pick: first requester at or after ptr.
// Revision: 1.0
// =============================================================================
module rr_arbiter_4
    import router_pkg::*;
(
    input  wire logic [3:0] req,
    input  wire logic [1:0] ptr,
    output port_idx_t       gnt_idx,
    output logic            gnt_vld
);

    port_idx_t w_cand;

    always_comb begin
        gnt_idx = ptr;
        gnt_vld = 1'b0;
        w_cand  = ptr;
        // Scan farthest-first so the nearest requester at/after ptr wins.
        for (int k = 3; k >= 0; k--) begin
            w_cand = ptr + port_idx_t'(k);
            if (req[w_cand]) begin
                gnt_idx = w_cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_port_drain_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : router_port_drain_arbiter
// Round-robin packet drain of four router ports into one tagged byte stream.
// Optional per-port packet counters: define ARB_PKT_CNT_EN.
// Revision: 1.0
// =============================================================================
module router_port_drain_arbiter
    import router_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int SKID_D = 2
`ifdef ARB_PKT_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    router_port_drain_arbiter_if.master bus
);

    localparam int c_PTR_W = (SKID_D > 2) ? $clog2(SKID_D) : 1;
    localparam int c_CW    = $clog2(SKID_D + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        port_idx_t         port;
        logic              sop;
        logic              eop;
    } skid_entry_t;

    arb_state_e        r_state;
    port_idx_t         r_ptr;
    port_idx_t         r_grant;
    logic              r_sop_pend;
    logic              r_inflight;
    skid_entry_t       r_skid [SKID_D];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    logic [3:0]        w_req;
    logic [3:0]        w_read;
    logic [DATA_W-1:0] w_data [4];
    port_idx_t         w_pick;
    logic              w_pick_vld;
    logic              w_ready_g;
    logic              w_room;
    logic              w_read_g;
    logic              w_out_valid;
    logic              w_pop;
    logic [c_CW:0]     w_used;
    skid_entry_t       w_head;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(SKID_D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_req     = {bus.ready_3, bus.ready_2, bus.ready_1, bus.ready_0};
    assign w_data[0] = bus.data_0;
    assign w_data[1] = bus.data_1;
    assign w_data[2] = bus.data_2;
    assign w_data[3] = bus.data_3;

    rr_arbiter_4 u_rr (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt_idx (w_pick),
        .gnt_vld (w_pick_vld)
    );

    // The byte already in flight from the router counts as occupying a slot.
    assign w_ready_g = w_req[r_grant];
    assign w_used    = {1'b0, r_count} + {{c_CW{1'b0}}, r_inflight};
    assign w_room    = (32'(w_used) + 32'd2) <= 32'(SKID_D);
    assign w_read_g  = (r_state == ST_XFER) && w_ready_g && w_room;

    always_comb begin
        w_read          = '0;
        w_read[r_grant] = w_read_g;
    end

    assign bus.read_0 = w_read[0];
    assign bus.read_1 = w_read[1];
    assign bus.read_2 = w_read[2];
    assign bus.read_3 = w_read[3];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_sop_pend <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_read_g;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant <= w_pick;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_ready_g) begin
                        r_sop_pend <= 1'b1;
                        r_state    <= ST_XFER;
                    end else begin
                        r_ptr   <= r_grant + 2'd1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (r_inflight) begin
                        r_sop_pend <= 1'b0;
                        // Router dropping ready at the capture edge marks the last byte.
                        if (!w_ready_g) begin
                            r_ptr   <= r_grant + 2'd1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_head      = r_skid[r_rd_ptr];
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SKID_D; i++) r_skid[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_inflight) begin
                r_skid[r_wr_ptr] <= '{data: w_data[r_grant], port: r_grant,
                                      sop: r_sop_pend, eop: !w_ready_g};
                r_wr_ptr         <= f_next(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_head.data;
    assign bus.out_port  = w_head.port;
    assign bus.out_sop   = w_head.sop;
    assign bus.out_eop   = w_head.eop;
    assign bus.busy      = (r_state != ST_IDLE) || w_out_valid;

`ifdef ARB_PKT_CNT_EN
    logic [CNT_W-1:0] r_pkt_cnt [4];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) r_pkt_cnt[i] <= '0;
        end else if (w_pop && w_head.eop) begin
            r_pkt_cnt[w_head.port] <= r_pkt_cnt[w_head.port] + 1'b1;
        end
    end

    assign bus.pkt_cnt_0 = r_pkt_cnt[0];
    assign bus.pkt_cnt_1 = r_pkt_cnt[1];
    assign bus.pkt_cnt_2 = r_pkt_cnt[2];
    assign bus.pkt_cnt_3 = r_pkt_cnt[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_port_drain_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : tb_router_port_drain_arbiter
// Self-checking bench: router port model, scoreboard of expected beats, vector table.
// Revision: 1.0
// =============================================================================
module tb_router_port_drain_arbiter;
    import router_pkg::*;

    localparam int SKID_D = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    router_port_drain_arbiter_if bus ();

    router_port_drain_arbiter #(.DATA_W(8), .SKID_D(SKID_D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] port;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct {
        int         port;
        int         len;
        logic [7:0] base;
        logic [7:0] exp_sop;
        logic [7:0] exp_eop;
    } vec_t;

    logic [7:0] q_src [4][$];
    logic       ready_v [4];
    logic [7:0] data_v [4];
    logic       out_ready;
    logic [3:0] reads;
    beat_t      exp_q [$];
    vec_t       vecs [4];
    int         checks = 0;
    int         failures = 0;
    int         popped = 0;
    int         occ = 0;
    int         infl = 0;
    logic [7:0] last_sop_data;
    logic [7:0] last_eop_data;
`ifdef ARB_PKT_CNT_EN
    int         exp_pkts [4];
`endif

    assign bus.ready_0   = ready_v[0];
    assign bus.ready_1   = ready_v[1];
    assign bus.ready_2   = ready_v[2];
    assign bus.ready_3   = ready_v[3];
    assign bus.data_0    = data_v[0];
    assign bus.data_1    = data_v[1];
    assign bus.data_2    = data_v[2];
    assign bus.data_3    = data_v[3];
    assign bus.out_ready = out_ready;
    assign reads = {bus.read_3, bus.read_2, bus.read_1, bus.read_0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Queue a packet at a router port and the beats it must produce downstream.
    task automatic load_pkt(input int port, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            q_src[port].push_back(base + 8'(i));
            exp_q.push_back({base + 8'(i), 2'(port), (i == 0), (i == len - 1)});
        end
        ready_v[port] = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clock);
            if (!bus.busy && exp_q.size() == 0 && q_src[0].size() == 0 &&
                q_src[1].size() == 0 && q_src[2].size() == 0 && q_src[3].size() == 0)
                done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_idle: busy=%b pending=%0d, required busy=0 pending=0",
                     name, bus.busy, exp_q.size());
        end
    endtask

    // Router port: a read seen in cycle t pops a byte that is valid in cycle t+1.
    initial begin : router_model
        logic [3:0] rd;
        forever begin
            @(negedge clock);
            rd = reads;
            @(posedge clock);
            #1;
            for (int n = 0; n < 4; n++) begin
                if (rd[n] && q_src[n].size() != 0) begin
                    data_v[n]  = q_src[n].pop_front();
                    ready_v[n] = (q_src[n].size() != 0);
                end
            end
        end
    end

    initial begin : monitor
        beat_t act;
        beat_t exp;
        logic  pop;
        forever begin
            @(negedge clock);
            if (!reset) begin
                occ  = 0;
                infl = 0;
            end else begin
                pop = bus.out_valid && out_ready;
                checks++;
                if (bus.out_valid !== (occ != 0)) begin
                    failures++;
                    $display("FAIL out_valid_timing: got %b required %b at %0t",
                             bus.out_valid, (occ != 0), $time);
                end
                if (reads != 4'h0) begin
                    checks++;
                    if ($countones(reads) != 1 || (SKID_D - occ - infl) < 2 ||
                        (reads & {ready_v[3], ready_v[2], ready_v[1], ready_v[0]}) != reads) begin
                        failures++;
                        $display("FAIL read_legal: reads=%b free=%0d at %0t, required one-hot, ready port, free>=2",
                                 reads, SKID_D - occ - infl, $time);
                    end
                end
                if (pop) begin
                    act = {bus.out_data, bus.out_port, bus.out_sop, bus.out_eop};
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL beat_unexpected: got 0x%0h required no beat at %0t", act, $time);
                    end else begin
                        exp = exp_q.pop_front();
                        if (act !== exp) begin
                            failures++;
                            $display("FAIL beat: got data=%0h port=%0d sop=%b eop=%b required data=%0h port=%0d sop=%b eop=%b",
                                     act.data, act.port, act.sop, act.eop,
                                     exp.data, exp.port, exp.sop, exp.eop);
                        end
                    end
                    if (act.sop) last_sop_data = act.data;
                    if (act.eop) begin
                        last_eop_data = act.data;
`ifdef ARB_PKT_CNT_EN
                        exp_pkts[act.port]++;
`endif
                    end
                    popped++;
                end
                occ  = occ + infl - (pop ? 1 : 0);
                infl = (reads != 4'h0) ? 1 : 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1);
    end

    initial begin : main
        int  k;
        int  start;
        bit  viol;
        bit  done;

        reset     = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            ready_v[n] = 1'b0;
            data_v[n]  = 8'h00;
`ifdef ARB_PKT_CNT_EN
            exp_pkts[n] = 0;
`endif
        end
        vecs[0] = '{2, 5, 8'hA0, 8'hA0, 8'hA4};
        vecs[1] = '{0, 1, 8'h55, 8'h55, 8'h55};
        vecs[2] = '{1, 4, 8'h30, 8'h30, 8'h33};
        vecs[3] = '{3, 2, 8'hC0, 8'hC0, 8'hC1};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_reads", reads, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_tags", {bus.out_port, bus.out_sop, bus.out_eop}, 0);
        reset = 1'b1;

        // Single packets, one port at a time; ends with ptr back at 0.
        for (int v = 0; v < 4; v++) begin
            last_sop_data = 8'h00;
            last_eop_data = 8'h00;
            @(posedge clock);
            #2;
            load_pkt(vecs[v].port, vecs[v].len, vecs[v].base);
            wait_idle("vec");
            chk("vec_sop_data", last_sop_data, vecs[v].exp_sop);
            chk("vec_eop_data", last_eop_data, vecs[v].exp_eop);
            chk("vec_busy", bus.busy, 0);
        end

        // All four requesting with ptr=0: order 0,1,2,3.
        @(posedge clock);
        #2;
        for (int p = 0; p < 4; p++) load_pkt(p, 3, 8'h40 + 8'(16 * p));
        wait_idle("rr_ptr0");

        // Move ptr to 2, then all four: order 2,3,0,1.
        @(posedge clock);
        #2;
        load_pkt(1, 1, 8'h77);
        wait_idle("rr_setup");
        @(posedge clock);
        #2;
        load_pkt(2, 3, 8'h82);
        load_pkt(3, 3, 8'h93);
        load_pkt(0, 3, 8'hA0 + 8'h10);
        load_pkt(1, 3, 8'hC1);
        wait_idle("rr_ptr2");

        // Backpressure mid-packet on port 1.
        @(posedge clock);
        #2;
        start = popped;
        load_pkt(1, 8, 8'h10);
        k = 0;
        while (popped < start + 3 && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("bp_progress", (popped >= start + 3), 1);
        @(posedge clock);
        #2;
        out_ready = 1'b0;
        start = popped;
        repeat (10) @(negedge clock);
        chk("bp_no_pop", popped - start, 0);
        chk("bp_read_1_full", reads[1], 0);
        chk("bp_out_valid_held", bus.out_valid, 1);
        @(posedge clock);
        #2;
        out_ready = 1'b1;
        wait_idle("bp");

        // Port 3 requests during a port 0 packet and must wait.
        @(posedge clock);
        #2;
        load_pkt(0, 6, 8'h60);
        k = 0;
        while (!reads[0] && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("cont_started", reads[0], 1);
        @(posedge clock);
        #2;
        load_pkt(3, 2, 8'hD0);
        viol = 1'b0;
        done = 1'b0;
        for (int j = 0; j < 400 && !done; j++) begin
            @(negedge clock);
            if (reads[3] && q_src[0].size() != 0) viol = 1'b1;
            if (!bus.busy && exp_q.size() == 0) done = 1'b1;
        end
        chk("no_preempt", viol, 0);
        chk("cont_idle", done, 1);

        // Empty packet on port 2: no beats, ptr advances to 3.
        @(posedge clock);
        #2;
        ready_v[2] = 1'b1;
        @(posedge clock);
        #2;
        ready_v[2] = 1'b0;
        wait_idle("empty");
        @(posedge clock);
        #2;
        load_pkt(3, 2, 8'hE0);
        load_pkt(0, 2, 8'hF0);
        wait_idle("empty_ptr3");

        // Reset during a port 1 packet, with ptr left at 2 beforehand.
        @(posedge clock);
        #2;
        load_pkt(1, 2, 8'h20);
        wait_idle("pre_reset");
        @(posedge clock);
        #2;
        load_pkt(1, 8, 8'h90);
        k = 0;
        while (!reads[1] && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("rst_mid_started", reads[1], 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_reads", reads, 0);
        chk("rst_mid_out_valid", bus.out_valid, 0);
        chk("rst_mid_busy", bus.busy, 0);
        exp_q.delete();
        q_src[1].delete();
        ready_v[1] = 1'b0;
`ifdef ARB_PKT_CNT_EN
        for (int n = 0; n < 4; n++) exp_pkts[n] = 0;
`endif
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #2;
        load_pkt(0, 2, 8'hB0);
        load_pkt(2, 2, 8'hB8);
        wait_idle("post_reset");

`ifdef ARB_PKT_CNT_EN
        @(posedge clock);
        #2;
        load_pkt(0, 2, 8'h01);
        wait_idle("cnt_a");
        @(posedge clock);
        #2;
        load_pkt(0, 3, 8'h05);
        wait_idle("cnt_b");
        @(posedge clock);
        #2;
        load_pkt(3, 1, 8'h09);
        wait_idle("cnt_c");
        chk("pkt_cnt_0", bus.pkt_cnt_0, exp_pkts[0]);
        chk("pkt_cnt_1", bus.pkt_cnt_1, exp_pkts[1]);
        chk("pkt_cnt_2", bus.pkt_cnt_2, exp_pkts[2]);
        chk("pkt_cnt_3", bus.pkt_cnt_3, exp_pkts[3]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
